// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit datapath between INPUTS requesters.
// A grant is held for a whole burst; ownership passes on only after a last beat.
module rr_mux_arbiter #(
   parameter  int WIDTH  = 8,
   parameter  int INPUTS = 4,
   localparam int WSEL   = $clog2(INPUTS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INPUTS-1:0]       req_valid,
   input  logic [INPUTS-1:0]       req_last,
   input  logic [WIDTH*INPUTS-1:0] req_data,
   output logic [INPUTS-1:0]       req_ready,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [WIDTH-1:0]        out_data,
   input  logic                    out_ready,
   output logic [WSEL-1:0]         grant,
   output logic                    busy
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WSEL-1:0]   ptr;
   logic [WSEL-1:0]   pick;
   logic [WSEL-1:0]   idx;
   logic              found;
   logic              any_req;
   logic              xfer;

   assign any_req = |req_valid;
   assign xfer    = out_valid & out_ready;

   // Search starts at ptr; WSEL-bit addition wraps INPUTS-1 back to 0.
   always_comb begin
      pick  = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < INPUTS; k++) begin
         idx = ptr + WSEL'(k);
         if (!found && req_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req)
            grant <= pick;
         if (state == OWN && xfer && out_last)
            ptr <= grant + WSEL'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (any_req) state_nxt = OWN;
         OWN:  if (xfer && out_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake: a beat moves on a rising edge where out_valid and out_ready are
   // both high; the owner sees that same edge as req_valid & req_ready. Only the
   // owner's ready is ever driven, and only while the grant is held.
   always_comb begin
      out_valid = 1'b0;
      req_ready = '0;
      busy      = (state == OWN);
      out_last  = req_last[grant];
      out_data  = req_data[WIDTH*grant +: WIDTH];
      if (state == OWN) begin
         out_valid        = req_valid[grant];
         req_ready[grant] = out_ready;
      end
   end

endmodule
